cpu_stage_ctrl: RTL and testbench

//  Multi-cycle sequencer for the core: walks each instruction through IF/ID/EX/MEM/WB and drives

---
 rtl/cpu_stage_ctrl.sv | 168 ++++++++++++++++
 tb/tb_cpu_stage_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_stage_ctrl.sv
// cpu_stage_ctrl: multi-cycle instruction sequencer.
// Moves each instruction through IF/ID/EX/MEM/WB, skips stages according to the
// opcode class, handshakes with instruction and data memory, counts retired
// instructions and traps illegal opcodes and memory timeouts into HALT.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   opcode[6:0]     instr[6:0] from the IR, classified in ID
//   imem_ready      instruction fetch complete
//   dmem_ready      data access complete
//   halt_req        external halt, honoured only on a retire cycle
//   control_status  current stage (IF=0 ID=1 EX=2 MEM=3 WB=4 HALT=5)
//   imem_req        fetch request, high throughout IF
//   ir_en           IR load strobe
//   dmem_req        data request, high throughout MEM
//   dmem_we         data write enable, store in MEM
//   pc_en           PC update strobe on retire
//   rf_wr_en        register-file write enable, WB only
//   retired         one-cycle retire pulse
//   retire_cnt      retired-instruction counter (wraps)
//   err             sticky illegal-opcode / memory-timeout flag
module cpu_stage_ctrl #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  input  logic             halt_req,
  output logic [2:0]       control_status,
  output logic             imem_req,
  output logic             ir_en,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             pc_en,
  output logic             rf_wr_en,
  output logic             retired,
  output logic [CNT_W-1:0] retire_cnt,
  output logic             err
);

  localparam int unsigned WAIT_W = 16;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IF   = 3'd0,
    ST_ID   = 3'd1,
    ST_EX   = 3'd2,
    ST_MEM  = 3'd3,
    ST_WB   = 3'd4,
    ST_HALT = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_WRITE,   // OP, OP-IMM, LUI, AUIPC, JAL, JALR: EX then WB
    CLS_SYSTEM,
    CLS_ILLEGAL
  } cls_t;

  state_t            state, state_nx;
  cls_t              cls_dec, cls_q;
  logic [WAIT_W-1:0] wait_cnt;
  logic              waiting;
  logic              timeout;
  logic              retire_now;
  logic              err_set;

  // Opcode classification (only meaningful while in ID)
  always_comb begin
    cls_dec = CLS_ILLEGAL;
    unique case (opcode)
      7'b0000011: cls_dec = CLS_LOAD;
      7'b0100011: cls_dec = CLS_STORE;
      7'b1100011: cls_dec = CLS_BRANCH;
      7'b0110011, 7'b0010011, 7'b0110111,
      7'b0010111, 7'b1101111, 7'b1100111: cls_dec = CLS_WRITE;
      7'b1110011: cls_dec = CLS_SYSTEM;
      default:    cls_dec = CLS_ILLEGAL;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IF;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx   = state;
    retire_now = 1'b0;
    waiting    = ((state == ST_IF) && !imem_ready) || ((state == ST_MEM) && !dmem_ready);
    // Ready on the last allowed cycle still wins: timeout needs !ready in that cycle
    timeout    = waiting && (wait_cnt == WAIT_LAST);
    unique case (state)
      ST_IF: begin
        if (imem_ready)   state_nx = ST_ID;
        else if (timeout) state_nx = ST_HALT;
      end
      ST_ID: begin
        state_nx = (cls_dec == CLS_ILLEGAL) ? ST_HALT : ST_EX;
      end
      ST_EX: begin
        unique case (cls_q)
          CLS_LOAD, CLS_STORE:     state_nx = ST_MEM;
          CLS_WRITE:               state_nx = ST_WB;
          CLS_BRANCH, CLS_SYSTEM:  retire_now = 1'b1;
          default:                 state_nx = ST_HALT;
        endcase
      end
      ST_MEM: begin
        if (dmem_ready) begin
          if (cls_q == CLS_STORE) retire_now = 1'b1;
          else                    state_nx = ST_WB;
        end else if (timeout) begin
          state_nx = ST_HALT;
        end
      end
      ST_WB:   retire_now = 1'b1;
      ST_HALT: state_nx = ST_HALT;
      default: state_nx = ST_HALT;
    endcase
    if (retire_now)
      state_nx = (halt_req || (cls_q == CLS_SYSTEM)) ? ST_HALT : ST_IF;
  end

  assign err_set = timeout || ((state == ST_ID) && (cls_dec == CLS_ILLEGAL));

  // Class, wait counter, retire counter and sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      cls_q      <= CLS_ILLEGAL;
      wait_cnt   <= '0;
      retire_cnt <= '0;
      err        <= 1'b0;
    end else begin
      if (state == ST_ID)
        cls_q <= cls_dec;
      if ((state_nx != state) && ((state_nx == ST_IF) || (state_nx == ST_MEM)))
        wait_cnt <= '0;
      else if (waiting && !timeout)
        wait_cnt <= wait_cnt + 1'b1;
      if (retire_now)
        retire_cnt <= retire_cnt + 1'b1;
      if (err_set)
        err <= 1'b1;
    end
  end

  // Output decode; strobes are masked during reset so an aborted instruction
  // never writes the register file or advances the PC.
  always_comb begin
    control_status = state;
    imem_req       = (state == ST_IF);
    dmem_req       = (state == ST_MEM);
    ir_en          = (state == ST_IF) && imem_ready && !rst;
    dmem_we        = (state == ST_MEM) && (cls_q == CLS_STORE) && !rst;
    rf_wr_en       = (state == ST_WB) && !rst;
    retired        = retire_now && !rst;
    pc_en          = retire_now && !rst;
  end

endmodule

// File: tb/tb_cpu_stage_ctrl.sv
// Directed testbench for cpu_stage_ctrl (MEM_TIMEOUT overridden to 4).
module tb_cpu_stage_ctrl;

  localparam int unsigned CNT_W = 32;

  localparam logic [6:0] OP_ADD  = 7'b0110011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_SYS  = 7'b1110011;
  localparam logic [6:0] OP_BAD  = 7'b0000000;

  logic             clk = 1'b0;
  logic             rst;
  logic [6:0]       opcode;
  logic             imem_ready;
  logic             dmem_ready;
  logic             halt_req;
  logic [2:0]       control_status;
  logic             imem_req;
  logic             ir_en;
  logic             dmem_req;
  logic             dmem_we;
  logic             pc_en;
  logic             rf_wr_en;
  logic             retired;
  logic [CNT_W-1:0] retire_cnt;
  logic             err;

  int n_checks = 0;
  int n_errors = 0;

  cpu_stage_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .imem_ready(imem_ready),
    .dmem_ready(dmem_ready), .halt_req(halt_req), .control_status(control_status),
    .imem_req(imem_req), .ir_en(ir_en), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .pc_en(pc_en), .rf_wr_en(rf_wr_en), .retired(retired),
    .retire_cnt(retire_cnt), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    rst        = 1'b1;
    opcode     = OP_ADD;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    halt_req   = 1'b0;
    reset_dut();
    check("rst_status", 32'(control_status), 0);
    check("rst_imem_req", 32'(imem_req), 1);
    check("rst_ir_en", 32'(ir_en), 0);
    check("rst_dmem_req", 32'(dmem_req), 0);
    check("rst_err", 32'(err), 0);
    check("rst_cnt", retire_cnt, 0);
    check("rst_retired", 32'(retired), 0);

    // ADD: IF ID EX WB IF
    opcode = OP_ADD; imem_ready = 1'b1; dmem_ready = 1'b1; #1;
    check("add_if_ir_en", 32'(ir_en), 1);
    tick(); check("add_id", 32'(control_status), 1);
    check("add_id_ir_en", 32'(ir_en), 0);
    tick(); check("add_ex", 32'(control_status), 2);
    check("add_ex_rf", 32'(rf_wr_en), 0);
    tick(); check("add_wb", 32'(control_status), 4);
    check("add_wb_rf", 32'(rf_wr_en), 1);
    check("add_wb_ret", 32'(retired), 1);
    check("add_wb_pc", 32'(pc_en), 1);
    tick(); check("add_if2", 32'(control_status), 0);
    check("add_cnt", retire_cnt, 1);
    check("add_if2_rf", 32'(rf_wr_en), 0);

    // LW, dmem_ready delayed 3 cycles
    opcode = OP_LW; dmem_ready = 1'b0;
    tick(); tick(); tick();
    check("lw_mem1", 32'(control_status), 3);
    check("lw_dmem_req", 32'(dmem_req), 1);
    check("lw_dmem_we", 32'(dmem_we), 0);
    check("lw_imem_req", 32'(imem_req), 0);
    tick(); tick(); tick();
    check("lw_mem4", 32'(control_status), 3);
    dmem_ready = 1'b1; #1;
    check("lw_mem4_ret", 32'(retired), 0);
    tick(); check("lw_wb", 32'(control_status), 4);
    check("lw_wb_rf", 32'(rf_wr_en), 1);
    tick(); check("lw_cnt", retire_cnt, 2);

    // SW then BEQ
    opcode = OP_SW;
    tick(); tick(); tick();
    check("sw_mem", 32'(control_status), 3);
    check("sw_we", 32'(dmem_we), 1);
    check("sw_ret", 32'(retired), 1);
    check("sw_rf", 32'(rf_wr_en), 0);
    tick(); check("sw_if", 32'(control_status), 0);
    check("sw_cnt", retire_cnt, 3);
    opcode = OP_BEQ;
    tick(); tick();
    check("beq_ex", 32'(control_status), 2);
    check("beq_ret", 32'(retired), 1);
    check("beq_rf", 32'(rf_wr_en), 0);
    tick(); check("beq_if", 32'(control_status), 0);
    check("beq_cnt", retire_cnt, 4);

    // halt_req high only in ID is ignored
    opcode = OP_ADD;
    tick(); halt_req = 1'b1;
    tick(); halt_req = 1'b0;
    tick(); tick();
    check("hq_early_if", 32'(control_status), 0);
    check("hq_early_cnt", retire_cnt, 5);

    // halt_req raised in EX of ADD
    tick(); tick(); halt_req = 1'b1;
    tick(); check("hq_wb_ret", 32'(retired), 1);
    tick(); check("hq_halt", 32'(control_status), 5);
    check("hq_cnt", retire_cnt, 6);
    check("hq_err", 32'(err), 0);
    check("hq_imem_req", 32'(imem_req), 0);
    halt_req = 1'b0;
    tick(); check("hq_stay", 32'(control_status), 5);
    check("hq_pc", 32'(pc_en), 0);

    // rst during MEM aborts the load
    reset_dut();
    check("rst2_cnt", retire_cnt, 0);
    opcode = OP_LW; dmem_ready = 1'b0;
    tick(); tick(); tick();
    check("rm_mem", 32'(control_status), 3);
    rst = 1'b1; dmem_ready = 1'b1; #1;
    check("rm_ret", 32'(retired), 0);
    check("rm_pc", 32'(pc_en), 0);
    tick(); rst = 1'b0; #1;
    check("rm_if", 32'(control_status), 0);
    check("rm_cnt", retire_cnt, 0);

    // rst during WB suppresses the write
    opcode = OP_ADD;
    tick(); tick(); tick();
    check("rw_wb", 32'(control_status), 4);
    rst = 1'b1; #1;
    check("rw_rf", 32'(rf_wr_en), 0);
    check("rw_ret", 32'(retired), 0);
    tick(); rst = 1'b0; #1;
    check("rw_if", 32'(control_status), 0);
    check("rw_cnt", retire_cnt, 0);

    // Illegal opcode
    opcode = OP_BAD;
    tick(); check("ill_id", 32'(control_status), 1);
    check("ill_id_ret", 32'(retired), 0);
    tick(); check("ill_halt", 32'(control_status), 5);
    check("ill_err", 32'(err), 1);
    check("ill_ret", 32'(retired), 0);
    tick(); check("ill_stay", 32'(control_status), 5);
    check("ill_cnt", retire_cnt, 0);
    reset_dut();
    check("ill_rst_status", 32'(control_status), 0);
    check("ill_rst_err", 32'(err), 0);

    // LW data timeout after 4 MEM cycles
    opcode = OP_LW; dmem_ready = 1'b0;
    tick(); tick(); tick(); tick(); tick(); tick();
    check("to_mem4", 32'(control_status), 3);
    check("to_mem4_err", 32'(err), 0);
    tick(); check("to_halt", 32'(control_status), 5);
    check("to_err", 32'(err), 1);
    check("to_cnt", retire_cnt, 0);
    reset_dut();

    // SYSTEM retires in EX then halts
    opcode = OP_SYS; dmem_ready = 1'b1;
    tick(); tick();
    check("sys_ex_ret", 32'(retired), 1);
    tick(); check("sys_halt", 32'(control_status), 5);
    check("sys_cnt", retire_cnt, 1);
    check("sys_err", 32'(err), 0);
    reset_dut();

    // Fetch timeout
    imem_ready = 1'b0;
    tick(); tick(); tick();
    check("ift_if4", 32'(control_status), 0);
    check("ift_if4_err", 32'(err), 0);
    tick(); check("ift_halt", 32'(control_status), 5);
    check("ift_err", 32'(err), 1);
    reset_dut();

    // JAL writes back
    opcode = OP_JAL; imem_ready = 1'b1;
    tick(); tick(); tick();
    check("jal_wb", 32'(control_status), 4);
    check("jal_rf", 32'(rf_wr_en), 1);
    tick(); check("jal_cnt", retire_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
